// File: rtl/cost_table_server_if.sv
// Load/serve bus between the table loader, the downstream JAM and cost_table_server.
// The master drives loads and JAM lookups; the slave is the cost table itself.
interface cost_table_server_if;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LB_W   = 10;

    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [IDX_W-1:0]  W;
    logic [IDX_W-1:0]  J;
    logic [DATA_W-1:0] Cost;
    logic              TableReady;
    logic [LB_W-1:0]   LowerBound;
    logic              JamValid;

    modport master (
        output load_start, load_valid, load_data, W, J, JamValid,
        input  load_ready, Cost, TableReady, LowerBound
    );

    modport slave (
        input  load_start, load_valid, load_data, W, J, JamValid,
        output load_ready, Cost, TableReady, LowerBound
    );
endinterface

// File: rtl/cost_table_server.sv
// 8x8 cost table: streamed row-major load with running row-minimum lower bound,
// then registered {W,J} lookups for the JAM until it reports a result.
module cost_table_server (
    input logic                CLK,
    input logic                RST,
    cost_table_server_if.slave bus
);
    localparam int unsigned DATA_W  = 7;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned LB_W    = 10;
    localparam int unsigned ENTRIES = 64;

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   rowmin;
    logic [LB_W-1:0]     sum;
    logic [LB_W-1:0]     lower_bound_q;
    logic [DATA_W-1:0]   cost_q;
    logic                load_ready_q;
    logic                table_ready_q;
    logic [DATA_W-1:0]   mem [ENTRIES];

    logic                restart_c;
    logic                accept_c;
    logic                last_beat_c;
    logic [DATA_W-1:0]   beat_min_c;
    logic [LB_W-1:0]     row_sum_c;

    // A load_start beat in LOAD restarts the load and its data is dropped.
    assign restart_c   = bus.load_start && (state == IDLE || state == LOAD);
    assign accept_c    = (state == LOAD) && bus.load_valid && load_ready_q && !bus.load_start;
    assign last_beat_c = accept_c && (idx == ADDR_W'(ENTRIES - 1));
    assign beat_min_c  = (idx[2:0] == 3'd0) ? bus.load_data
                       : ((bus.load_data < rowmin) ? bus.load_data : rowmin);
    assign row_sum_c   = sum + LB_W'(beat_min_c);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.load_start) next_state = LOAD;
            LOAD:    if (last_beat_c)    next_state = SERVE;
            SERVE:   if (bus.JamValid)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs follow the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_ready_q  <= 1'b0;
            table_ready_q <= 1'b0;
            cost_q        <= '0;
        end else begin
            load_ready_q  <= (next_state == LOAD);
            table_ready_q <= (next_state == SERVE);
            cost_q        <= (next_state == SERVE) ? mem[{bus.W, bus.J}] : '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx           <= '0;
            rowmin        <= '0;
            sum           <= '0;
            lower_bound_q <= '0;
        end else if (restart_c) begin
            idx           <= '0;
            sum           <= '0;
            lower_bound_q <= '0;
        end else if (accept_c) begin
            idx    <= idx + ADDR_W'(1);
            rowmin <= beat_min_c;
            if (idx[2:0] == 3'd7) sum           <= row_sum_c;
            if (last_beat_c)      lower_bound_q <= row_sum_c;
        end
    end

    // Table storage is deliberately not reset; it survives IDLE between loads.
    always_ff @(posedge CLK) begin
        if (accept_c) mem[idx] <= bus.load_data;
    end

    assign bus.load_ready = load_ready_q;
    assign bus.TableReady = table_ready_q;
    assign bus.Cost       = cost_q;
    assign bus.LowerBound = lower_bound_q;
endmodule

// File: tb/tb_cost_table_server.sv
// Scoreboarded bench for cost_table_server: table loads, lower bound, lookups,
// restart, mid-load reset and JAM hand-back.
module tb_cost_table_server;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    cost_table_server_if bus();

    cost_table_server dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [6:0]  vals [64];
    logic [6:0]  mdl  [64];
    logic [6:0]  exp_q [$];
    bit          in_serve = 0;
    int          edges;
    int          accepts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [9:0] model_lb();
        logic [9:0] s;
        logic [6:0] m;
        s = '0;
        for (int r = 0; r < 8; r++) begin
            m = vals[r*8];
            for (int c = 1; c < 8; c++)
                if (vals[r*8+c] < m) m = vals[r*8+c];
            s = s + 10'(m);
        end
        return s;
    endfunction

    // Drives one lookup; the expected Cost is queued now and compared a cycle later.
    task automatic read_cost(input logic [2:0] w, input logic [2:0] j);
        logic [5:0] a;
        a = {w, j};
        bus.W = w;
        bus.J = j;
        exp_q.push_back(in_serve ? mdl[a] : 7'd0);
        step();
        check("cost", 32'(bus.Cost), 32'(exp_q.pop_front()));
    endtask

    task automatic do_load(input bit toggle, input int restart_at,
                           output int n_edges, output int n_acc);
        int  k;
        bit  phase;
        bit  restarted;
        bit  acc;
        bus.load_start = 1'b1;
        bus.load_valid = 1'b0;
        step();
        n_edges   = 1;
        k         = 0;
        phase     = 1'b0;
        restarted = 1'b0;
        check("load_ready_on", 32'(bus.load_ready), 32'd1);
        while (bus.TableReady !== 1'b1 && n_edges < 600) begin
            bus.load_start = 1'b0;
            if (restart_at >= 0 && !restarted && k == restart_at) begin
                bus.load_start = 1'b1;
                bus.load_valid = 1'b1;
                bus.load_data  = 7'd0;
                step();
                n_edges++;
                restarted = 1'b1;
                k = 0;
            end else begin
                bus.load_valid = (k < 64) && (!toggle || phase);
                bus.load_data  = (restart_at >= 0 && !restarted) ? 7'd1
                               : ((k < 64) ? vals[k] : 7'd0);
                acc = bus.load_valid && bus.load_ready;
                step();
                n_edges++;
                phase = ~phase;
                if (acc) begin
                    if (k < 64 && (restart_at < 0 || restarted)) mdl[k] = vals[k];
                    k++;
                end
            end
        end
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        n_acc = k;
        check("load_done", 32'(bus.TableReady), 32'd1);
        in_serve = (bus.TableReady === 1'b1);
    endtask

    task automatic jam_done();
        bus.JamValid = 1'b1;
        in_serve = 0;
        step();
        bus.JamValid = 1'b0;
        check("jam_table_ready", 32'(bus.TableReady), 32'd0);
        check("jam_cost", 32'(bus.Cost), 32'd0);
    endtask

    task automatic random_reads(input int n);
        logic [5:0] a;
        for (int i = 0; i < n; i++) begin
            a = 6'($urandom);
            read_cost(a[5:3], a[2:0]);
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.W = '0;
        bus.J = '0;
        bus.JamValid = 1'b0;
        repeat (2) step();
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_table_ready", 32'(bus.TableReady), 32'd0);
        check("rst_cost", 32'(bus.Cost), 32'd0);
        check("rst_lower_bound", 32'(bus.LowerBound), 32'd0);
        RST = 1'b0;
        step();

        // Identity table, continuous valid.
        for (int k = 0; k < 64; k++) vals[k] = 7'(k);
        do_load(1'b0, -1, edges, accepts);
        check("ident_edges", 32'(edges), 32'd65);
        check("ident_accepts", 32'(accepts), 32'd64);
        check("ident_lb", 32'(bus.LowerBound), 32'd224);
        read_cost(3'd3, 3'd5);
        read_cost(3'd7, 3'd7);
        read_cost(3'd0, 3'd0);
        random_reads(6);

        // load_start during SERVE is ignored.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("serve_start_tr", 32'(bus.TableReady), 32'd1);
        check("serve_start_lb", 32'(bus.LowerBound), 32'd224);
        check("serve_start_rdy", 32'(bus.load_ready), 32'd0);
        read_cost(3'd2, 3'd3);

        bus.W = 3'd2;
        bus.J = 3'd3;
        jam_done();
        check("jam_lb_hold", 32'(bus.LowerBound), 32'd224);
        bus.JamValid = 1'b1;
        step();
        bus.JamValid = 1'b0;
        check("idle_jam_tr", 32'(bus.TableReady), 32'd0);
        check("idle_jam_rdy", 32'(bus.load_ready), 32'd0);
        read_cost(3'd7, 3'd7);

        // All-127 table, valid toggling every other cycle.
        for (int k = 0; k < 64; k++) vals[k] = 7'd127;
        do_load(1'b1, -1, edges, accepts);
        check("max_accepts", 32'(accepts), 32'd64);
        check("max_lb", 32'(bus.LowerBound), 32'd1016);
        random_reads(4);
        jam_done();

        // Restart after 20 beats, then 64 beats of 5.
        for (int k = 0; k < 64; k++) vals[k] = 7'd5;
        do_load(1'b0, 20, edges, accepts);
        check("restart_accepts", 32'(accepts), 32'd64);
        check("restart_lb", 32'(bus.LowerBound), 32'd40);
        random_reads(4);
        jam_done();

        // Reset asserted at beat 30 abandons the load.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            bus.load_data = 7'($urandom);
            step();
        end
        #2 RST = 1'b1;
        #1;
        check("midrst_load_ready", 32'(bus.load_ready), 32'd0);
        check("midrst_table_ready", 32'(bus.TableReady), 32'd0);
        check("midrst_cost", 32'(bus.Cost), 32'd0);
        check("midrst_lb", 32'(bus.LowerBound), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_idle_rdy", 32'(bus.load_ready), 32'd0);
            check("postrst_idle_tr", 32'(bus.TableReady), 32'd0);
        end
        bus.load_valid = 1'b0;

        // Full random load after the aborted one.
        for (int k = 0; k < 64; k++) vals[k] = 7'($urandom);
        do_load(1'b0, -1, edges, accepts);
        check("rand_edges", 32'(edges), 32'd65);
        check("rand_lb", 32'(bus.LowerBound), 32'(model_lb()));
        random_reads(10);
        jam_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
